cordic_seq_ctrl: RTL and testbench
==================================

Name: cordic_seq_ctrl

Overview:
- Sequencer for the ROTATION CORDIC datapath.
- Accepts a job with a 2-bit mode: CIRCULAR, HYPERBOLIC or LINEAR, using the encodings from the shared CONSTANTS macros.
- Drives the iteration stage with a per-cycle shift amount, then strobes the Scaler for gain compensation, then presents a valid/ack result handshake.
- Sits between the job source and the iteration/Scaler datapath. Owns no arithmetic.

Parameters:
- ITERATIONS, 16, number of base iteration indices; range 6..31.
- SHIFT_W, 5, width of shift_amt; must hold ITERATIONS-1.
- SCALE_LATENCY, 1, cycles scale_en is held high per job; range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when ready=1.
- mode  in  2  job mode; sampled on acceptance.
- abort  in  1  synchronous cancel of the current job.
- ready  out  1  high in IDLE only.
- busy  out  1  high in LOAD, ITER and SCALE.
- load_init  out  1  one-cycle strobe; datapath loads its initial x/y/z.
- iter_en  out  1  datapath performs one micro-rotation this cycle.
- shift_amt  out  SHIFT_W  shift/table index for the current iteration.
- mode_q  out  2  latched job mode; held from acceptance until return to IDLE.
- scale_en  out  1  Scaler input register enable.
- out_valid  out  1  result available.
- out_ack  in  1  consumer accepts the result.
- err  out  1  one-cycle pulse on an illegal-mode start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=1.
  - busy, load_init, iter_en, scale_en, out_valid, err = 0.
  - shift_amt=0, mode_q=0, internal counters=0.
  - Reset mid-job discards the job; no strobe may glitch high during reset.
- States: IDLE, LOAD, ITER, SCALE, DONE. ready, busy and out_valid are decoded from the state register (Moore).
- IDLE:
  - start=1 with a legal mode: latch mode_q, go to LOAD.
  - start=1 with mode not equal to any of the three constants: err=1 for the next cycle only, stay in IDLE, mode_q unchanged.
- LOAD:
  - load_init=1 for exactly one cycle.
  - Go to ITER with shift_amt preset to the first index.
- ITER: iter_en=1 every cycle. shift_amt sequence per mode:
  - CIRCULAR and LINEAR: 0,1,...,ITERATIONS-1, giving ITERATIONS cycles.
  - HYPERBOLIC: starts at 1. Indices 4 and 13 are issued twice on consecutive cycles; 13 is repeated only if 13 < ITERATIONS.
  - HYPERBOLIC with default ITERATIONS gives 1,2,3,4,4,5,...,13,13,14,15 = 17 cycles.
  - After the last index: CIRCULAR or HYPERBOLIC go to SCALE; LINEAR goes directly to DONE (unit gain, Scaler bypassed).
- SCALE:
  - scale_en=1 for SCALE_LATENCY cycles, counted by an internal counter.
  - Then go to DONE.
- DONE:
  - out_valid=1 until out_ack=1 is sampled, then go to IDLE; ready=1 the next cycle.
  - out_valid and mode_q are stable while waiting.
- Latency, acceptance edge = t, defaults:
  - CIRCULAR: out_valid first high at t+19.
  - HYPERBOLIC: out_valid first high at t+20.
  - LINEAR: out_valid first high at t+18.
- Ignored inputs:
  - start while not in IDLE is ignored (no queuing, no err).
  - out_ack outside DONE is ignored.
- abort:
  - In LOAD, ITER or SCALE: go to IDLE next cycle; all strobes low that cycle; no out_valid.
  - In DONE: abort acts as out_ack.
  - In IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins.
- Back-to-back: out_ack in cycle u gives ready at u+1; a new start is accepted at u+1 at the earliest.
- shift_amt holds its last value outside ITER. Reset is the only event that clears it.

Test Plan:
- Reset, then CIRCULAR start at t: load_init at t+1; iter_en t+2..t+17 with shift_amt 0..15; scale_en at t+18; out_valid at t+19; ack gives ready at the next cycle.
- HYPERBOLIC start: shift_amt trace is exactly 1,2,3,4,4,5,...,12,13,13,14,15 (17 iter_en cycles); scale_en once; out_valid at t+20.
- LINEAR start: 16 iter cycles, scale_en never asserts, out_valid at t+18; holding out_ack low for 5 cycles keeps out_valid and mode_q stable.
- Illegal mode (the one unused 2-bit code) with start in IDLE: err pulses for exactly 1 cycle; ready stays 1; no load_init.
- Circular job with abort at shift_amt=7: next cycle IDLE, iter_en=0, out_valid never rises; start during ITER is ignored (no err).
- rst_n driven low asynchronously mid-ITER (between clock edges): all outputs go to reset values immediately; after release, a new HYPERBOLIC job completes normally.

Source files
------------

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the rotation CORDIC datapath: load, per-cycle shift index, Scaler strobe, result handshake.
// Owns no arithmetic; every strobe is decoded from the state register, so none can glitch during reset.
module cordic_seq_ctrl #(
   parameter int ITERATIONS    = 16,
   parameter int SHIFT_W       = 5,
   parameter int SCALE_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               abort,
   output logic               ready,
   output logic               busy,
   output logic               load_init,
   output logic               iter_en,
   output logic [SHIFT_W-1:0] shift_amt,
   output logic [1:0]         mode_q,
   output logic               scale_en,
   output logic               out_valid,
   input  logic               out_ack,
   output logic               err
);

   localparam logic [1:0] MODE_CIRCULAR   = 2'd0;
   localparam logic [1:0] MODE_HYPERBOLIC = 2'd1;
   localparam logic [1:0] MODE_LINEAR     = 2'd2;

   localparam logic [SHIFT_W-1:0] LAST_IDX = SHIFT_W'(ITERATIONS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ITER, SCALE, DONE} state_t;

   state_t             state, state_nxt;
   logic [SHIFT_W-1:0] shift_nxt;
   logic               rep, rep_nxt;
   logic [2:0]         scale_cnt, scale_cnt_nxt;
   logic [1:0]         mode_nxt;
   logic               err_nxt;
   logic               mode_legal;
   logic               need_rep;

   assign mode_legal = (mode == MODE_CIRCULAR) || (mode == MODE_HYPERBOLIC) ||
                       (mode == MODE_LINEAR);

   // Hyperbolic convergence needs indices 4 and 13 issued twice; rep marks the second issue.
   assign need_rep = (mode_q == MODE_HYPERBOLIC) && !rep &&
                     ((shift_amt == SHIFT_W'(4)) ||
                      ((ITERATIONS > 13) && (shift_amt == SHIFT_W'(13))));

   always_comb begin
      state_nxt     = state;
      shift_nxt     = shift_amt;
      rep_nxt       = rep;
      scale_cnt_nxt = scale_cnt;
      mode_nxt      = mode_q;
      err_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (mode_legal) begin
                  mode_nxt  = mode;
                  state_nxt = LOAD;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = ITER;
               shift_nxt = (mode_q == MODE_HYPERBOLIC) ? SHIFT_W'(1) : '0;
               rep_nxt   = 1'b0;
            end
         end
         ITER: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (need_rep) begin
               rep_nxt = 1'b1;
            end else if (shift_amt == LAST_IDX) begin
               rep_nxt       = 1'b0;
               scale_cnt_nxt = '0;
               // Linear mode has unit gain, so the Scaler is bypassed.
               state_nxt     = (mode_q == MODE_LINEAR) ? DONE : SCALE;
            end else begin
               shift_nxt = shift_amt + 1'b1;
               rep_nxt   = 1'b0;
            end
         end
         SCALE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (scale_cnt == 3'(SCALE_LATENCY - 1)) begin
               state_nxt = DONE;
            end else begin
               scale_cnt_nxt = scale_cnt + 3'd1;
            end
         end
         DONE: begin
            if (out_ack || abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_amt <= '0;
         rep       <= 1'b0;
         scale_cnt <= '0;
         mode_q    <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_amt <= shift_nxt;
         rep       <= rep_nxt;
         scale_cnt <= scale_cnt_nxt;
         mode_q    <= mode_nxt;
         err       <= err_nxt;
      end
   end

   assign ready     = (state == IDLE);
   assign busy      = (state == LOAD) || (state == ITER) || (state == SCALE);
   assign load_init = (state == LOAD);
   assign iter_en   = (state == ITER);
   assign scale_en  = (state == SCALE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: per-mode timing and shift traces, illegal mode, abort, async reset.
module tb_cordic_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       abort = 1'b0;
   logic       out_ack = 1'b0;
   logic       ready, busy, load_init, iter_en, scale_en, out_valid, err;
   logic [4:0] shift_amt;
   logic [1:0] mode_q;

   int n_cmp = 0;
   int n_bad = 0;

   int load_cyc, n_load, first_iter, last_iter, n_iter, first_scale, n_scale, valid_cyc;
   int trace[$];
   int hyp_exp[17] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15};
   bit found;
   bit saw_valid;

   cordic_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .ready     (ready),
      .busy      (busy),
      .load_init (load_init),
      .iter_en   (iter_en),
      .shift_amt (shift_amt),
      .mode_q    (mode_q),
      .scale_en  (scale_en),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents start in the current cycle (t) and records events for cycles t+1.. until out_valid.
   task automatic run_job(input logic [1:0] m);
      start = 1'b1;
      mode  = m;
      step();
      start = 1'b0;
      load_cyc = -1; n_load = 0; first_iter = -1; last_iter = -1; n_iter = 0;
      first_scale = -1; n_scale = 0; valid_cyc = -1;
      trace.delete();
      for (int k = 1; k <= 40; k++) begin
         if (load_init) begin
            if (load_cyc < 0) load_cyc = k;
            n_load++;
         end
         if (iter_en) begin
            if (first_iter < 0) first_iter = k;
            last_iter = k;
            n_iter++;
            trace.push_back(int'(shift_amt));
         end
         if (scale_en) begin
            if (first_scale < 0) first_scale = k;
            n_scale++;
         end
         if (out_valid) begin
            valid_cyc = k;
            break;
         end
         step();
      end
   endtask

   task automatic wait_shift(input int v);
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (iter_en && shift_amt == 5'(v)) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk($sformatf("reach_shift_%0d", v), 32'(found), 32'd1);
   endtask

   task automatic ack_result();
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      chk("ack_ready", 32'(ready), 32'd1);
      chk("ack_valid_low", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({load_init, iter_en, scale_en, out_valid, err}), 32'd0);
      chk("rst_shift", 32'(shift_amt), 32'd0);
      chk("rst_mode_q", 32'(mode_q), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      // Circular
      run_job(2'd0);
      chk("circ_load_cyc", load_cyc, 32'd1);
      chk("circ_n_load", n_load, 32'd1);
      chk("circ_first_iter", first_iter, 32'd2);
      chk("circ_last_iter", last_iter, 32'd17);
      chk("circ_n_iter", n_iter, 32'd16);
      for (int i = 0; i < 16 && i < trace.size(); i++)
         chk($sformatf("circ_shift[%0d]", i), trace[i], i);
      chk("circ_first_scale", first_scale, 32'd18);
      chk("circ_n_scale", n_scale, 32'd1);
      chk("circ_valid_cyc", valid_cyc, 32'd19);
      chk("circ_mode_q", 32'(mode_q), 32'd0);
      ack_result();
      chk("circ_shift_hold", 32'(shift_amt), 32'd15);

      // Hyperbolic
      run_job(2'd1);
      chk("hyp_n_iter", n_iter, 32'd17);
      for (int i = 0; i < 17 && i < trace.size(); i++)
         chk($sformatf("hyp_shift[%0d]", i), trace[i], hyp_exp[i]);
      chk("hyp_first_scale", first_scale, 32'd19);
      chk("hyp_n_scale", n_scale, 32'd1);
      chk("hyp_valid_cyc", valid_cyc, 32'd20);
      chk("hyp_mode_q", 32'(mode_q), 32'd1);
      ack_result();

      // Linear, with the consumer stalling, then abort acting as ack
      run_job(2'd2);
      chk("lin_n_iter", n_iter, 32'd16);
      chk("lin_n_scale", n_scale, 32'd0);
      chk("lin_valid_cyc", valid_cyc, 32'd18);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("lin_hold_valid", 32'(out_valid), 32'd1);
         chk("lin_hold_mode_q", 32'(mode_q), 32'd2);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("lin_abort_ack_ready", 32'(ready), 32'd1);
      chk("lin_abort_ack_valid", 32'(out_valid), 32'd0);

      // Illegal mode
      start = 1'b1;
      mode  = 2'd3;
      step();
      start = 1'b0;
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_ready", 32'(ready), 32'd1);
      chk("ill_load", 32'(load_init), 32'd0);
      chk("ill_mode_q", 32'(mode_q), 32'd2);
      step();
      chk("ill_err_once", 32'(err), 32'd0);
      chk("ill_ready2", 32'(ready), 32'd1);

      // Abort mid-ITER, with an ignored start during ITER
      start = 1'b1;
      mode  = 2'd0;
      step();
      start = 1'b0;
      wait_shift(3);
      start = 1'b1;
      mode  = 2'd3;
      step();
      start = 1'b0;
      chk("iter_start_no_err", 32'(err), 32'd0);
      chk("iter_start_ignored", 32'(shift_amt), 32'd4);
      wait_shift(7);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_iter_en", 32'(iter_en), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_strobes", 32'({busy, load_init, scale_en, out_valid}), 32'd0);
      chk("abort_shift_hold", 32'(shift_amt), 32'd7);
      saw_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out_valid) saw_valid = 1'b1;
      end
      chk("abort_no_valid", 32'(saw_valid), 32'd0);

      // Asynchronous reset mid-ITER, then a clean hyperbolic job
      start = 1'b1;
      mode  = 2'd1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("pre_rst_iter", 32'(iter_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_busy_iter", 32'({busy, iter_en}), 32'd0);
      chk("arst_shift", 32'(shift_amt), 32'd0);
      chk("arst_mode_q", 32'(mode_q), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      #2 rst_n = 1'b1;
      step();
      run_job(2'd1);
      chk("post_rst_n_iter", n_iter, 32'd17);
      chk("post_rst_n_scale", n_scale, 32'd1);
      chk("post_rst_valid_cyc", valid_cyc, 32'd20);
      ack_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
